// File: rtl/uop_seq_pkg.sv
// uop_seq_pkg: shared constants for the micro-op sequencer.
//   - micro-op bit indices driven by the fixed fetch sequence and memory ops
//   - opcode constants understood by the dispatch table
//   - FSM state encoding, microcode word layout and condition encodings
//   - helpers to build ROM words and to expand a word into the 49-bit vector
package uop_seq_pkg;

    localparam int UOP_W = 49;

    localparam logic [5:0] UOP_DREAD  = 6'd0;
    localparam logic [5:0] UOP_IREAD  = 6'd1;
    localparam logic [5:0] UOP_DWRITE = 6'd10;
    localparam logic [5:0] UOP_PCINC  = 6'd26;
    localparam logic [5:0] UOP_ARPC   = 6'd38;
    localparam logic [5:0] UOP_IRDR   = 6'd47;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_LOAD  = 8'h01;
    localparam logic [7:0] OP_STORE = 8'h02;
    localparam logic [7:0] OP_JMPZ  = 8'h20;
    localparam logic [7:0] OP_JMPNZ = 8'h21;
    localparam logic [7:0] OP_END   = 8'hFF;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_F_AR  = 3'd1;
    localparam state_t ST_F_RD  = 3'd2;
    localparam state_t ST_F_IR  = 3'd3;
    localparam state_t ST_F_INC = 3'd4;
    localparam state_t ST_DEC   = 3'd5;
    localparam state_t ST_EXEC  = 3'd6;
    localparam state_t ST_HALT  = 3'd7;

    // ROM word: {uop_idx[5:0], nop, last, cond[1:0]}
    localparam int ROM_W     = 10;
    localparam int W_IDX_HI  = 9;
    localparam int W_IDX_LO  = 4;
    localparam int W_NOP     = 3;
    localparam int W_LAST    = 2;
    localparam int W_COND_HI = 1;
    localparam int W_COND_LO = 0;

    localparam logic [1:0] COND_NONE    = 2'b00;
    localparam logic [1:0] COND_SKIP_NZ = 2'b01;  // skip next word when Z==0
    localparam logic [1:0] COND_SKIP_Z  = 2'b10;  // skip next word when Z==1
    localparam logic [1:0] COND_RSVD    = 2'b11;  // behaves as COND_NONE

    function automatic logic [ROM_W-1:0] mk_word(input logic [5:0] idx, input logic nop,
                                                 input logic last, input logic [1:0] cond);
        return {idx, nop, last, cond};
    endfunction

    function automatic logic [UOP_W-1:0] uop_onehot(input logic [5:0] idx, input logic nop);
        logic [UOP_W-1:0] v;
        v = '0;
        if (!nop && (idx <= 6'd48)) begin
            v = {{(UOP_W-1){1'b0}}, 1'b1} << idx;
        end
        return v;
    endfunction

    // Memory micro-ops are stretched by the wait-state counter.
    function automatic logic is_mem_uop(input logic [5:0] idx, input logic nop);
        return !nop && ((idx == UOP_DREAD) || (idx == UOP_IREAD) || (idx == UOP_DWRITE));
    endfunction

endpackage

// File: rtl/uop_rom.sv
// uop_rom: combinational opcode dispatch table and 64x10 microcode ROM.
//   op_i    opcode to dispatch
//   upc_i   microcode address to read
//   base_o  first microcode address of op_i
//   valid_o op_i has an entry in the dispatch table (OP_END has none)
//   word_o  ROM word at upc_i
// Unprogrammed words read back as a no-op that returns to fetch.
module uop_rom
    import uop_seq_pkg::*;
#(
    parameter int UPC_W = 6,
    parameter int OP_W  = 8
) (
    input  logic [OP_W-1:0]  op_i,
    input  logic [UPC_W-1:0] upc_i,
    output logic [UPC_W-1:0] base_o,
    output logic             valid_o,
    output logic [ROM_W-1:0] word_o
);

    always_comb begin
        base_o  = '0;
        valid_o = 1'b0;
        case (op_i)
            OP_W'(OP_NOP):   begin base_o = UPC_W'(0);  valid_o = 1'b1; end
            OP_W'(OP_LOAD):  begin base_o = UPC_W'(4);  valid_o = 1'b1; end
            OP_W'(OP_STORE): begin base_o = UPC_W'(8);  valid_o = 1'b1; end
            OP_W'(OP_JMPZ):  begin base_o = UPC_W'(12); valid_o = 1'b1; end
            OP_W'(OP_JMPNZ): begin base_o = UPC_W'(16); valid_o = 1'b1; end
            default:         begin base_o = '0;         valid_o = 1'b0; end
        endcase
    end

    always_comb begin
        word_o = mk_word(6'd0, 1'b1, 1'b1, COND_NONE);
        case (upc_i)
            // OP_NOP: two idle words
            UPC_W'(0):  word_o = mk_word(6'd0,       1'b1, 1'b0, COND_NONE);
            UPC_W'(1):  word_o = mk_word(6'd0,       1'b1, 1'b1, COND_NONE);
            // OP_LOAD: the data read may skip the following word when Z==0
            UPC_W'(4):  word_o = mk_word(6'd5,       1'b0, 1'b0, COND_NONE);
            UPC_W'(5):  word_o = mk_word(UOP_DREAD,  1'b0, 1'b0, COND_SKIP_NZ);
            UPC_W'(6):  word_o = mk_word(6'd20,      1'b0, 1'b0, COND_NONE);
            UPC_W'(7):  word_o = mk_word(6'd21,      1'b0, 1'b1, COND_NONE);
            // OP_STORE: skip on a last word has no effect
            UPC_W'(8):  word_o = mk_word(UOP_DWRITE, 1'b0, 1'b0, COND_NONE);
            UPC_W'(9):  word_o = mk_word(6'd33,      1'b0, 1'b1, COND_SKIP_Z);
            // OP_JMPZ: PCINC is skipped when Z==1
            UPC_W'(12): word_o = mk_word(6'd3,       1'b0, 1'b0, COND_SKIP_Z);
            UPC_W'(13): word_o = mk_word(UOP_PCINC,  1'b0, 1'b0, COND_NONE);
            UPC_W'(14): word_o = mk_word(6'd48,      1'b0, 1'b1, COND_NONE);
            // OP_JMPNZ: index 50 is out of range and issues nothing
            UPC_W'(16): word_o = mk_word(6'd4,       1'b0, 1'b0, COND_SKIP_NZ);
            UPC_W'(17): word_o = mk_word(6'd7,       1'b0, 1'b0, COND_NONE);
            UPC_W'(18): word_o = mk_word(6'd50,      1'b0, 1'b0, COND_RSVD);
            UPC_W'(19): word_o = mk_word(6'd9,       1'b0, 1'b1, COND_NONE);
            default:    word_o = mk_word(6'd0,       1'b1, 1'b1, COND_NONE);
        endcase
    end

endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: microprogrammed control sequencer, one micro-op per cycle.
//   CLK, RESET_N   core clock, asynchronous active-low reset
//   START          one-cycle pulse, honoured only in IDLE or HALT
//   STEP           only with SINGLE_STEP_EN defined: advance enable
//   INS            opcode, sampled in DEC
//   Z              ALU zero flag, sampled in the final cycle of each word
//   uOPs           registered one-hot (or zero) micro-op vector
//   BUSY, DONE     registered state flags; ERR sticky undefined-opcode flag
// Optional macro: SINGLE_STEP_EN.
//
// state  | meaning
// IDLE   | waiting for START after reset
// F_AR   | ARPC: address register <- PC
// F_RD   | IREAD held 1+MEM_WAIT cycles
// F_IR   | IRDR: instruction register load
// F_INC  | PCINC
// DEC    | dispatch on INS
// EXEC   | walking microcode ROM
// HALT   | DONE=1, waiting for START
module uop_sequencer
    import uop_seq_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int UPC_W    = 6,
    parameter int OP_W     = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
`ifdef SINGLE_STEP_EN
    input  logic             STEP,
`endif
    input  logic [OP_W-1:0]  INS,
    input  logic             Z,
    output logic [48:0]      uOPs,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_RELOAD = WAIT_W'(MEM_WAIT);

    state_t             state_q, state_d;
    logic [UPC_W-1:0]   upc_q, upc_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               err_q, err_d;
    logic               last_q;
    logic [1:0]         cond_q;
    logic [UOP_W-1:0]   uops_q, uops_d;
    logic               busy_q, done_q;

    logic               adv;
    logic               load_fetch, load_word, count_down;
    logic               skip;
    logic [UPC_W-1:0]   disp_base;
    logic               disp_valid;
    logic [ROM_W-1:0]   rom_word;
    logic [5:0]         rom_idx;
    logic               rom_nop;

`ifdef SINGLE_STEP_EN
    assign adv = STEP;
`else
    assign adv = 1'b1;
`endif

    // The ROM is read at the next upc so uOPs can be registered alongside
    // state; last/cond of the word being issued are kept in last_q/cond_q.
    uop_rom #(
        .UPC_W (UPC_W),
        .OP_W  (OP_W)
    ) u_rom (
        .op_i    (INS),
        .upc_i   (upc_d),
        .base_o  (disp_base),
        .valid_o (disp_valid),
        .word_o  (rom_word)
    );

    assign rom_idx = rom_word[W_IDX_HI:W_IDX_LO];
    assign rom_nop = rom_word[W_NOP];
    assign skip    = ((cond_q == COND_SKIP_NZ) && !Z) || ((cond_q == COND_SKIP_Z) && Z);

    always_comb begin
        state_d    = state_q;
        upc_d      = upc_q;
        err_d      = err_q;
        load_fetch = 1'b0;
        load_word  = 1'b0;
        count_down = 1'b0;
        if (adv) begin
            case (state_q)
                ST_IDLE: begin
                    if (START) state_d = ST_F_AR;
                end
                ST_F_AR: begin
                    state_d    = ST_F_RD;
                    load_fetch = 1'b1;
                end
                ST_F_RD: begin
                    if (wait_q != '0) count_down = 1'b1;
                    else              state_d    = ST_F_IR;
                end
                ST_F_IR:  state_d = ST_F_INC;
                ST_F_INC: state_d = ST_DEC;
                ST_DEC: begin
                    if (INS == OP_W'(OP_END)) begin
                        state_d = ST_HALT;
                    end else if (!disp_valid) begin
                        err_d   = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        upc_d     = disp_base;
                        state_d   = ST_EXEC;
                        load_word = 1'b1;
                    end
                end
                ST_EXEC: begin
                    if (wait_q != '0) begin
                        count_down = 1'b1;
                    end else if (last_q) begin
                        state_d = ST_F_AR;
                    end else begin
                        upc_d     = upc_q + (skip ? UPC_W'(2) : UPC_W'(1));
                        load_word = 1'b1;
                    end
                end
                ST_HALT: begin
                    if (START) begin
                        state_d = ST_F_AR;
                        err_d   = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (load_fetch) begin
            wait_d = WAIT_RELOAD;
        end else if (load_word) begin
            wait_d = is_mem_uop(rom_idx, rom_nop) ? WAIT_RELOAD : '0;
        end else if (count_down) begin
            wait_d = wait_q - WAIT_W'(1);
        end
    end

    always_comb begin
        uops_d = '0;
        case (state_d)
            ST_F_AR:  uops_d = uop_onehot(UOP_ARPC,  1'b0);
            ST_F_RD:  uops_d = uop_onehot(UOP_IREAD, 1'b0);
            ST_F_IR:  uops_d = uop_onehot(UOP_IRDR,  1'b0);
            ST_F_INC: uops_d = uop_onehot(UOP_PCINC, 1'b0);
            ST_EXEC:  uops_d = uop_onehot(rom_idx, rom_nop);
            default:  uops_d = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            cond_q  <= COND_NONE;
            uops_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            last_q  <= rom_word[W_LAST];
            cond_q  <= rom_word[W_COND_HI:W_COND_LO];
            uops_q  <= uops_d;
            busy_q  <= (state_d != ST_IDLE) && (state_d != ST_HALT);
            done_q  <= (state_d == ST_HALT);
        end
    end

    assign uOPs = uops_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign ERR  = err_q;

endmodule

// File: tb/tb_uop_sequencer.sv
module tb_uop_sequencer;

    localparam int MW = 1;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b1;
    logic        START = 1'b0;
    logic [7:0]  INS = 8'h00;
    logic        Z = 1'b0;
    logic [48:0] uOPs;
    logic        BUSY, DONE, ERR;
`ifdef SINGLE_STEP_EN
    logic        STEP = 1'b1;
`endif

    uop_sequencer #(.MEM_WAIT(MW), .UPC_W(6), .OP_W(8)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
`ifdef SINGLE_STEP_EN
        .STEP    (STEP),
`endif
        .INS     (INS),
        .Z       (Z),
        .uOPs    (uOPs),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 CLK = ~CLK;

    // Expected per-cycle outputs plus the inputs to present during that cycle.
    typedef struct {
        logic [48:0] uops;
        logic        busy;
        logic        done;
        logic        err;
        logic        start;
        logic [7:0]  ins;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   model_err = 0;
    bit   model_halt = 0;
    bit   allow_rs = 0;
    bit   man_start = 0;
    logic [7:0] man_ins = 8'h00;
    bit   man_z = 0;

    // Reference microcode, by address.
    int ridx[64];
    bit rnop[64];
    bit rlast[64];
    int rcond[64];

    task automatic set_w(input int a, input int idx, input bit nop, input bit last, input int cond);
        ridx[a] = idx; rnop[a] = nop; rlast[a] = last; rcond[a] = cond;
    endtask

    task automatic rom_init();
        for (int i = 0; i < 64; i++) set_w(i, 0, 1, 1, 0);
        set_w(0, 0, 1, 0, 0);  set_w(1, 0, 1, 1, 0);
        set_w(4, 5, 0, 0, 0);  set_w(5, 0, 0, 0, 1);  set_w(6, 20, 0, 0, 0); set_w(7, 21, 0, 1, 0);
        set_w(8, 10, 0, 0, 0); set_w(9, 33, 0, 1, 2);
        set_w(12, 3, 0, 0, 2); set_w(13, 26, 0, 0, 0); set_w(14, 48, 0, 1, 0);
        set_w(16, 4, 0, 0, 1); set_w(17, 7, 0, 0, 0); set_w(18, 50, 0, 0, 3); set_w(19, 9, 0, 1, 0);
    endtask

    function automatic bit defined_op(input logic [7:0] op);
        return (op == 8'h00) || (op == 8'h01) || (op == 8'h02) || (op == 8'h20) || (op == 8'h21);
    endfunction

    function automatic int base_of(input logic [7:0] op);
        case (op)
            8'h01:   return 4;
            8'h02:   return 8;
            8'h20:   return 12;
            8'h21:   return 16;
            default: return 0;
        endcase
    endfunction

    function automatic logic [48:0] vec(input int idx, input bit nop);
        logic [48:0] one;
        one = 49'(1);
        if (nop || idx > 48) return 49'(0);
        return one << idx;
    endfunction

    function automatic bit rs();
        return allow_rs && ($urandom_range(0, 7) == 0);
    endfunction

    task automatic push(input logic [48:0] u, input bit busy, input bit done, input bit start,
                        input logic [7:0] ins, input bit z);
        exp_t e;
        e.uops = u; e.busy = busy; e.done = done; e.err = model_err;
        e.start = start; e.ins = ins; e.z = z;
        exp_q.push_back(e);
    endtask

    // One cycle in IDLE/HALT with START asserted.
    task automatic gen_begin();
        push(49'(0), 0, model_halt, 1, 8'h00, 0);
        model_err = 0;
        model_halt = 0;
    endtask

    task automatic gen_instr(input logic [7:0] op, input bit z, input bit busy_start, input bit dec_start);
        int pc;
        int n;
        int guard;
        bit skip;
        push(vec(38, 0), 1, 0, rs(), op, z);
        for (int i = 0; i < 1 + MW; i++) push(vec(1, 0), 1, 0, rs(), op, z);
        push(vec(47, 0), 1, 0, busy_start | rs(), op, z);
        push(vec(26, 0), 1, 0, rs(), op, z);
        push(49'(0), 1, 0, dec_start | rs(), op, z);
        if (op == 8'hFF || !defined_op(op)) begin
            if (op != 8'hFF) model_err = 1;
            model_halt = 1;
            push(49'(0), 0, 1, 0, op, z);
            push(49'(0), 0, 1, 0, op, z);
        end else begin
            pc = base_of(op);
            guard = 0;
            while (guard < 64) begin
                n = (!rnop[pc] && (ridx[pc] == 0 || ridx[pc] == 1 || ridx[pc] == 10)) ? 1 + MW : 1;
                for (int i = 0; i < n; i++) push(vec(ridx[pc], rnop[pc]), 1, 0, rs(), op, z);
                if (rlast[pc]) break;
                skip = (rcond[pc] == 1 && !z) || (rcond[pc] == 2 && z);
                pc = (pc + (skip ? 2 : 1)) % 64;
                guard++;
            end
        end
    endtask

    task automatic chk(input string nm, input logic [48:0] act, input logic [48:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: one expected entry per cycle, inputs for the same cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            n_chk++;
            if ($countones(uOPs) > 1) begin
                n_fail++;
                $display("FAIL onehot: uOPs %h has %0d bits set, expected at most 1", uOPs, $countones(uOPs));
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("uops", uOPs, e.uops);
                chk1("busy", BUSY, e.busy);
                chk1("done", DONE, e.done);
                chk1("err", ERR, e.err);
                START = e.start;
                INS = e.ins;
                Z = e.z;
            end else begin
                START = man_start;
                INS = man_ins;
                Z = man_z;
            end
        end
    end

    task automatic run_wait(input string nm);
        int k;
        k = 0;
        while (exp_q.size() > 0 && k < 600) begin
            @(negedge CLK); #1;
            k++;
        end
        n_chk++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL %s: timeout with %0d entries left, expected 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_for(input string nm, input logic [48:0] target);
        int k;
        k = 0;
        while (uOPs !== target && k < 50) begin
            @(negedge CLK); #1;
            k++;
        end
        chk(nm, uOPs, target);
    endtask

    task automatic do_reset();
        RESET_N = 0;
        repeat (2) @(negedge CLK);
        #1 RESET_N = 1;
        model_err = 0;
        model_halt = 0;
    endtask

    initial begin
        logic [7:0] op;
        int nins;
        rom_init();

        #1 RESET_N = 0;
        repeat (3) @(negedge CLK);
        #1 RESET_N = 1;
        @(negedge CLK); #1;
        chk("rst_uops", uOPs, 49'(0));
        chk1("rst_busy", BUSY, 0);
        chk1("rst_done", DONE, 0);
        chk1("rst_err", ERR, 0);

        // Reset held during instruction read.
        man_ins = 8'h00;
        man_start = 1;
        wait_for("fetch_ar", 49'h40_0000_0000);
        man_start = 0;
        wait_for("fetch_rd", 49'h2);
        RESET_N = 0;
        #1;
        chk("rst_frd_uops", uOPs, 49'(0));
        chk1("rst_frd_busy", BUSY, 0);
        repeat (2) @(negedge CLK);
        #1 RESET_N = 1;
        model_err = 0; model_halt = 0;
        @(negedge CLK); #1;
        chk("idle_uops", uOPs, 49'(0));
        chk1("idle_busy", BUSY, 0);
        chk1("idle_done", DONE, 0);
        chk1("idle_err", ERR, 0);

        // NOP then END; START during the DEC that enters HALT must be ignored.
        gen_begin();
        gen_instr(8'h00, 0, 1, 0);
        gen_instr(8'hFF, 0, 0, 1);
        chk("pin_nop_len", 49'(exp_q.size()), 49'd17);
        chk("pin_nop_ar", exp_q[1].uops, 49'h40_0000_0000);
        chk("pin_nop_rd", exp_q[3].uops, 49'h2);
        chk("pin_nop_ir", exp_q[4].uops, 49'h8000_0000_0000);
        chk("pin_nop_inc", exp_q[5].uops, 49'h400_0000);
        chk("pin_nop_again", exp_q[9].uops, 49'h40_0000_0000);
        run_wait("nop_prog");

        // JMPZ with Z=1 then Z=0.
        gen_begin();
        gen_instr(8'h20, 1, 0, 0);
        gen_instr(8'hFF, 0, 0, 0);
        chk("pin_jmpz1_w0", exp_q[7].uops, 49'h8);
        chk("pin_jmpz1_w2", exp_q[8].uops, 49'h1_0000_0000_0000);
        run_wait("jmpz_z1");
        gen_begin();
        gen_instr(8'h20, 0, 0, 0);
        gen_instr(8'hFF, 0, 0, 0);
        chk("pin_jmpz0_w1", exp_q[8].uops, 49'h400_0000);
        run_wait("jmpz_z0");

        // Undefined opcode, then a restart that clears ERR.
        gen_begin();
        gen_instr(8'h7E, 0, 1, 0);
        gen_begin();
        gen_instr(8'h02, 1, 0, 0);
        gen_instr(8'hFF, 0, 0, 0);
        run_wait("undef_prog");

        // Randomized programs with stray START pulses while busy.
        allow_rs = 1;
        for (int p = 0; p < 25; p++) begin
            gen_begin();
            nins = $urandom_range(1, 4);
            for (int i = 0; i < nins; i++) begin
                case ($urandom_range(0, 4))
                    0: op = 8'h00;
                    1: op = 8'h01;
                    2: op = 8'h02;
                    3: op = 8'h20;
                    default: op = 8'h21;
                endcase
                gen_instr(op, 1'($urandom_range(0, 1)), 0, 0);
            end
            if ($urandom_range(0, 9) < 7) begin
                op = 8'hFF;
            end else begin
                op = 8'($urandom_range(0, 255));
                while (defined_op(op) || op == 8'hFF) op = 8'($urandom_range(0, 255));
            end
            gen_instr(op, 0, 0, 0);
            run_wait("rand_prog");
        end
        allow_rs = 0;

        // Asynchronous reset in the middle of a data read.
        man_ins = 8'h01;
        man_z = 0;
        man_start = 1;
        wait_for("load_ar", 49'h40_0000_0000);
        man_start = 0;
        wait_for("load_dread", 49'h1);
        RESET_N = 0;
        #1;
        chk("async_uops", uOPs, 49'(0));
        chk1("async_busy", BUSY, 0);
        chk1("async_done", DONE, 0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
